// File: rtl/imu_frame_deser_if.sv
// rtl/imu_frame_deser_if.sv - byte stream in, decoded acceleration samples out
interface imu_frame_deser_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [15:0] ax_out;
  logic [15:0] az_out;
  logic        valid_out;
  logic        frame_err;
  logic [7:0]  err_count;

  // Byte source side: drives the raw stream, observes decoded results
  modport master (
    output byte_in, byte_valid,
    input  ax_out, az_out, valid_out, frame_err, err_count
  );

  // Deframer side
  modport slave (
    input  byte_in, byte_valid,
    output ax_out, az_out, valid_out, frame_err, err_count
  );
endinterface

// File: rtl/imu_frame_deser.sv
// rtl/imu_frame_deser.sv - IMU sync-byte deframer; IMU_DESER_CHECKSUM_EN adds trailing checksum
module imu_frame_deser #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  imu_frame_deser_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AX_HI,
    S_AX_LO,
    S_AZ_HI,
`ifdef IMU_DESER_CHECKSUM_EN
    S_AZ_LO,
    S_CSUM
`else
    S_AZ_LO
`endif
  } state_t;

  // Counter value whose next idle cycle would complete the timeout
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_idle_cnt;
  logic [7:0] r_ax_hi;
  logic [7:0] r_ax_lo;
  logic [7:0] r_az_hi;
`ifdef IMU_DESER_CHECKSUM_EN
  logic [7:0] r_az_lo;
  logic [7:0] w_sum;
`endif
  logic       w_accept;
  logic       w_reject;
  logic       w_timeout;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state: one step per consumed byte, timeout forces back to hunting
  always_comb begin
    w_next = r_state;
    if (w_timeout) begin
      w_next = S_IDLE;
    end else if (bus.byte_valid) begin
      case (r_state)
        S_IDLE:  if (bus.byte_in == SYNC_BYTE) w_next = S_AX_HI;
        S_AX_HI: w_next = S_AX_LO;
        S_AX_LO: w_next = S_AZ_HI;
        S_AZ_HI: w_next = S_AZ_LO;
`ifdef IMU_DESER_CHECKSUM_EN
        S_AZ_LO: w_next = S_CSUM;
        S_CSUM:  w_next = S_IDLE;
`else
        S_AZ_LO: w_next = S_IDLE;
`endif
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Frame outcome decode: accept, checksum reject, or mid-frame timeout
  always_comb begin
    w_accept  = 1'b0;
    w_reject  = 1'b0;
    w_timeout = (r_state != S_IDLE) && !bus.byte_valid && (r_idle_cnt == TIMEOUT_LAST);
`ifdef IMU_DESER_CHECKSUM_EN
    w_sum = r_ax_hi + r_ax_lo + r_az_hi + r_az_lo;
    if (bus.byte_valid && r_state == S_CSUM) begin
      if (bus.byte_in == w_sum) w_accept = 1'b1;
      else                      w_reject = 1'b1;
    end
`else
    if (bus.byte_valid && r_state == S_AZ_LO) w_accept = 1'b1;
`endif
  end

  // Idle counter: only runs mid-frame, cleared by any consumed byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                              r_idle_cnt <= 8'd0;
    else if (r_state == S_IDLE || bus.byte_valid || w_timeout) r_idle_cnt <= 8'd0;
    else                                                  r_idle_cnt <= r_idle_cnt + 8'd1;
  end

  // Shadow payload capture; a timed-out partial frame is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_timeout) begin
      r_ax_hi <= 8'd0;
      r_ax_lo <= 8'd0;
      r_az_hi <= 8'd0;
`ifdef IMU_DESER_CHECKSUM_EN
      r_az_lo <= 8'd0;
`endif
    end else if (bus.byte_valid) begin
      case (r_state)
        S_AX_HI: r_ax_hi <= bus.byte_in;
        S_AX_LO: r_ax_lo <= bus.byte_in;
        S_AZ_HI: r_az_hi <= bus.byte_in;
`ifdef IMU_DESER_CHECKSUM_EN
        S_AZ_LO: r_az_lo <= bus.byte_in;
`endif
        default: ;
      endcase
    end
  end

  // Registered outputs: sample publish, error pulse and saturating error count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ax_out    <= 16'd0;
      bus.az_out    <= 16'd0;
      bus.valid_out <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.err_count <= 8'd0;
    end else begin
      bus.valid_out <= w_accept;
      bus.frame_err <= w_reject || w_timeout;
      if (w_accept) begin
        bus.ax_out <= {r_ax_hi, r_ax_lo};
`ifdef IMU_DESER_CHECKSUM_EN
        bus.az_out <= {r_az_hi, r_az_lo};
`else
        bus.az_out <= {r_az_hi, bus.byte_in};
`endif
      end
      if ((w_reject || w_timeout) && bus.err_count != 8'hFF)
        bus.err_count <= bus.err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_imu_frame_deser.sv
// tb/tb_imu_frame_deser.sv - directed bench for imu_frame_deser
module tb_imu_frame_deser;

`ifdef IMU_DESER_CHECKSUM_EN
  localparam int FRAME_LEN = 6;
`else
  localparam int FRAME_LEN = 5;
`endif

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   cyc;
  int   last_v;
  int   prev_v;
  int   err_seen;
  int   exp_err;
  int   err_before;
  logic early_err;

  imu_frame_deser_if bus ();

  imu_frame_deser #(.SYNC_BYTE(8'hA5), .TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge; return at the next falling edge so
  // outputs produced by the intervening rising edge are visible.
  task automatic step(input logic v, input logic [7:0] b);
    bus.byte_valid = v;
    bus.byte_in    = b;
    @(negedge clk);
    cyc++;
    if (bus.valid_out === 1'b1) begin
      prev_v = last_v;
      last_v = cyc;
    end
    if (bus.frame_err === 1'b1) err_seen++;
  endtask

  task automatic send_frame(input logic [15:0] ax, input logic [15:0] az, input logic bad);
    logic [7:0] sum;
    sum = ax[15:8] + ax[7:0] + az[15:8] + az[7:0];
    step(1'b1, 8'hA5);
    step(1'b1, ax[15:8]);
    step(1'b1, ax[7:0]);
    step(1'b1, az[15:8]);
    step(1'b1, az[7:0]);
`ifdef IMU_DESER_CHECKSUM_EN
    step(1'b1, bad ? sum + 8'd1 : sum);
`else
    if (bad) step(1'b0, sum);
`endif
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; last_v = -100; prev_v = -100;
    err_seen = 0; exp_err = 0;
    rst = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_ax", bus.ax_out, 16'h0000);
    check("reset_az", bus.az_out, 16'h0000);
    check("reset_valid", bus.valid_out, 1'b0);
    check("reset_err", bus.frame_err, 1'b0);
    check("reset_cnt", bus.err_count, 8'h00);
    rst = 1'b0;
    step(1'b0, 8'h00);

    // Good frame
    send_frame(16'h1234, 16'hABCD, 1'b0);
    check("good_valid", bus.valid_out, 1'b1);
    check("good_ax", bus.ax_out, 16'h1234);
    check("good_az", bus.az_out, 16'hABCD);
    step(1'b0, 8'h00);
    check("good_pulse_1cyc", bus.valid_out, 1'b0);

    // Garbage then frame
    err_before = err_seen;
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    step(1'b1, 8'h3C);
    send_frame(16'h8001, 16'h7FFF, 1'b0);
    check("garbage_valid", bus.valid_out, 1'b1);
    check("garbage_ax", bus.ax_out, 16'h8001);
    check("garbage_az", bus.az_out, 16'h7FFF);
    check("garbage_no_err", err_seen - err_before, 0);
    step(1'b0, 8'h00);

`ifdef IMU_DESER_CHECKSUM_EN
    // Bad checksum
    send_frame(16'h1234, 16'hABCD, 1'b0);
    send_frame(16'h1234, 16'hABCD, 1'b1);
    exp_err++;
    check("badcs_err", bus.frame_err, 1'b1);
    check("badcs_valid", bus.valid_out, 1'b0);
    check("badcs_cnt", bus.err_count, exp_err);
    check("badcs_ax_hold", bus.ax_out, 16'h1234);
    check("badcs_az_hold", bus.az_out, 16'hABCD);
    step(1'b0, 8'h00);
    check("badcs_pulse_1cyc", bus.frame_err, 1'b0);
`endif

    // Timeout after A5, 12
    step(1'b1, 8'hA5);
    step(1'b1, 8'h12);
    early_err = 1'b0;
    for (int i = 0; i < 63; i++) begin
      step(1'b0, 8'h00);
      if (bus.frame_err !== 1'b0) early_err = 1'b1;
    end
    check("timeout_not_early", early_err, 1'b0);
    step(1'b0, 8'h00);
    exp_err++;
    check("timeout_err", bus.frame_err, 1'b1);
    check("timeout_cnt", bus.err_count, exp_err);
    step(1'b0, 8'h00);
    check("timeout_pulse_1cyc", bus.frame_err, 1'b0);
    send_frame(16'h5566, 16'h7788, 1'b0);
    check("after_to_valid", bus.valid_out, 1'b1);
    check("after_to_ax", bus.ax_out, 16'h5566);
    check("after_to_az", bus.az_out, 16'h7788);
    step(1'b0, 8'h00);

    // Byte arriving on the would-be timeout cycle wins
    err_before = err_seen;
    step(1'b1, 8'hA5);
    step(1'b1, 8'h12);
    repeat (63) step(1'b0, 8'h00);
    step(1'b1, 8'h34);
    step(1'b1, 8'hAB);
`ifdef IMU_DESER_CHECKSUM_EN
    step(1'b1, 8'hCD);
    step(1'b1, 8'hBE);
`else
    step(1'b1, 8'hCD);
`endif
    check("bytewins_valid", bus.valid_out, 1'b1);
    check("bytewins_ax", bus.ax_out, 16'h1234);
    check("bytewins_no_err", err_seen - err_before, 0);
    step(1'b0, 8'h00);

    // Streaming back to back
    err_before = err_seen;
    send_frame(16'h0102, 16'h0304, 1'b0);
    send_frame(16'hFEDC, 16'hBA98, 1'b0);
    check("stream_spacing", last_v - prev_v, FRAME_LEN);
    check("stream_ax", bus.ax_out, 16'hFEDC);
    check("stream_az", bus.az_out, 16'hBA98);
    check("stream_no_err", err_seen - err_before, 0);
    step(1'b0, 8'h00);

    // Asynchronous reset mid-frame
    step(1'b1, 8'hA5);
    step(1'b1, 8'h12);
    bus.byte_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_ax", bus.ax_out, 16'h0000);
    check("midrst_az", bus.az_out, 16'h0000);
    check("midrst_cnt", bus.err_count, 8'h00);
    check("midrst_valid", bus.valid_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_err = 0;
    send_frame(16'h1234, 16'hABCD, 1'b0);
    check("postrst_valid", bus.valid_out, 1'b1);
    check("postrst_ax", bus.ax_out, 16'h1234);
    check("postrst_az", bus.az_out, 16'hABCD);
    step(1'b0, 8'h00);

    // Error counter saturation
    for (int i = 0; i < 255; i++) begin
      step(1'b1, 8'hA5);
      repeat (64) step(1'b0, 8'h00);
    end
    check("sat_cnt_255", bus.err_count, 8'hFF);
    step(1'b1, 8'hA5);
    repeat (64) step(1'b0, 8'h00);
    check("sat_err_pulse", bus.frame_err, 1'b1);
    check("sat_cnt_hold", bus.err_count, 8'hFF);
    check("sat_ax_hold", bus.ax_out, 16'h1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
